// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WORDS*SIZE-bit add done one SIZE-bit word per clock,
// least-significant word first, with the carry chained through a register.
// Optional build macro WIDE_ADD_SUB_EN adds a `sub` input (A-B via invert+1).

// One SIZE-bit adder slice; the only arithmetic in the sequencer.
module full_adder #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] x,
   input  logic [SIZE-1:0] y,
   input  logic            ci,
   output logic [SIZE-1:0] s,
   output logic            co
);
   assign {co, s} = {1'b0, x} + {1'b0, y} + {{SIZE{1'b0}}, ci};
endmodule

module wide_add_sequencer #(
   parameter int SIZE  = 8,
   parameter int WORDS = 4,
   localparam int W    = WORDS * SIZE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
`ifdef WIDE_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q, res_q, res_next;
   logic [CW-1:0]   idx_q;
   logic            carry_q;
   logic [SIZE-1:0] word_s;
   logic            word_co;
   logic            accept, last, sub_i;

`ifdef WIDE_ADD_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign last   = (idx_q == CW'(WORDS - 1));

   // Operands shift down one word per RUN cycle, so the slice always sees word 0.
   full_adder #(.SIZE(SIZE)) u_slice (
      .x  (a_q[SIZE-1:0]),
      .y  (b_q[SIZE-1:0]),
      .ci (carry_q),
      .s  (word_s),
      .co (word_co)
   );

   // Result words enter at the top and shift down; after WORDS cycles they are aligned.
   generate
      if (WORDS == 1) begin : g_one
         assign res_next = word_s;
      end else begin : g_many
         assign res_next = {word_s, res_q[W-1:SIZE]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; DONE accepts a new start just like IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Datapath: capture on accept, one word per RUN cycle, publish on the last word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b ^ {W{sub_i}};
         idx_q   <= '0;
         carry_q <= sub_i;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> SIZE;
         b_q     <= b_q >> SIZE;
         res_q   <= res_next;
         carry_q <= word_co;
         if (last) begin
            sum  <= res_next;
            cout <= word_co;
         end else begin
            idx_q <= idx_q + CW'(1);
         end
      end
   end
endmodule
